// File: rtl/uart_pkg.sv
// Shared definitions for the APB UART: register offsets, bit positions,
// FSM encodings and the parity helper used by both serial paths.
package uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_DIV    = 2'd3;

    localparam int ST_TX_EMPTY   = 0;
    localparam int ST_TX_FULL    = 1;
    localparam int ST_RX_EMPTY   = 2;
    localparam int ST_RX_FULL    = 3;
    localparam int ST_RX_OVR     = 4;
    localparam int ST_FRAME_ERR  = 5;
    localparam int ST_PARITY_ERR = 6;
    localparam int ST_TX_OVF     = 7;
    localparam int ST_TX_BUSY    = 8;

    localparam int CT_TX_EN        = 0;
    localparam int CT_RX_EN        = 1;
    localparam int CT_PAR_EN       = 2;
    localparam int CT_PAR_ODD      = 3;
    localparam int CT_IRQ_RX_EN    = 4;
    localparam int CT_IRQ_ERR_EN   = 5;
    localparam int CT_IRQ_TXE_EN   = 6;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Even parity is the XOR of the data bits; odd parity is its inverse.
    // Narrower characters are zero-extended, which leaves the XOR unchanged.
    function automatic logic parity_of(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO with wrap-bit pointers. A pop in the same
// cycle frees a slot, so a push while full still lands when paired with a pop.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Pointer advance; the extra MSB distinguishes full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/apb_uart_fifo.sv
// APB UART with TX/RX FIFOs, programmable divisor, optional parity,
// sticky error flags and a registered level interrupt.
module apb_uart_fifo #(
    parameter int         CLOCK_RATE = 100000000,
    parameter int         BAUD_RATE  = 9600,
    parameter int         DATA_BITS  = 8,
    parameter int         FIFO_DEPTH = 8,
    parameter logic [1:0] PSEL_ID    = 2'b10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pAdd,
    input  logic [31:0] pwData,
    input  logic        pwr,
    input  logic [1:0]  psel,
    input  logic        pen,
    input  logic        rxd,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        txd,
    output logic        irq
);

    import uart_pkg::*;

    localparam int         DIV_RESET_INT = CLOCK_RATE / BAUD_RATE;
    localparam logic [15:0] DIV_RESET    = DIV_RESET_INT[15:0];
    localparam logic [2:0]  LAST_BIT     = 3'(DATA_BITS - 1);

    logic                 access, wr_acc, rd_acc, w1c_hit;
    logic [1:0]           addr;
    logic [6:0]           ctrl;
    logic [15:0]          div_reg;
    logic                 rx_ovr, frame_err, parity_err, tx_ovf;
    logic                 set_rx_ovr, set_frame_err, set_parity_err, set_tx_ovf;
    logic [8:0]           status;

    logic                 tx_push, tx_pop, tx_full, tx_empty;
    logic [DATA_BITS-1:0] tx_dout;
    logic                 rx_push, rx_pop, rx_full, rx_empty;
    logic [DATA_BITS-1:0] rx_dout;

    tx_state_t            tx_state, tx_state_nx;
    logic                 tx_start, tx_bit_end, tx_busy;
    logic [15:0]          tx_cnt, tx_div;
    logic [2:0]           tx_bit;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par_en, tx_par_bit;

    rx_state_t            rx_state, rx_state_nx;
    logic                 rx_begin, rx_done, rx_bit_end, rx_fall, rx_good, rx_par_bad;
    logic                 rxd_s1, rxd_s2, rxd_prev;
    logic [15:0]          rx_cnt, rx_div;
    logic [2:0]           rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par_en, rx_par_odd, rx_par_bit;

    logic                 unused_bits;

    assign unused_bits = ^{pAdd[31:4], pAdd[1:0], pwData[31:16]};

    assign access  = (psel == PSEL_ID) && pen;
    assign wr_acc  = access && pwr;
    assign rd_acc  = access && !pwr;
    assign addr    = pAdd[3:2];
    assign pready  = access;
    assign w1c_hit = wr_acc && (addr == REG_STATUS);

    assign tx_push    = wr_acc && (addr == REG_DATA);
    assign rx_pop     = rd_acc && (addr == REG_DATA) && !rx_empty;
    assign set_tx_ovf = tx_push && tx_full && !tx_pop;

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (pwData[DATA_BITS-1:0]),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_empty)
    );

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (rx_shift),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // Gather the status word from FIFO flags, sticky errors and TX activity.
    always_comb begin
        status                = '0;
        status[ST_TX_EMPTY]   = tx_empty;
        status[ST_TX_FULL]    = tx_full;
        status[ST_RX_EMPTY]   = rx_empty;
        status[ST_RX_FULL]    = rx_full;
        status[ST_RX_OVR]     = rx_ovr;
        status[ST_FRAME_ERR]  = frame_err;
        status[ST_PARITY_ERR] = parity_err;
        status[ST_TX_OVF]     = tx_ovf;
        status[ST_TX_BUSY]    = tx_busy;
    end

    // Read mux; the bus sees zero outside access cycles and on an empty RX read.
    always_comb begin
        prdata = '0;
        if (access) begin
            case (addr)
                REG_DATA:   if (!rx_empty) prdata[DATA_BITS-1:0] = rx_dout;
                REG_STATUS: prdata[8:0]  = status;
                REG_CTRL:   prdata[6:0]  = ctrl;
                REG_DIV:    prdata[15:0] = div_reg;
                default:    prdata = '0;
            endcase
        end
    end

    // Control and divisor registers; divisors below 2 would break mid-bit sampling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl    <= '0;
            div_reg <= DIV_RESET;
        end else if (wr_acc) begin
            if (addr == REG_CTRL) ctrl <= pwData[6:0];
            if (addr == REG_DIV)  div_reg <= (pwData[15:1] == 15'd0) ? 16'd2 : pwData[15:0];
        end
    end

    // Sticky flags: a hardware set in the same cycle overrides a W1C clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ovr     <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            tx_ovf     <= 1'b0;
        end else begin
            rx_ovr     <= (rx_ovr     & ~(w1c_hit & pwData[ST_RX_OVR]))     | set_rx_ovr;
            frame_err  <= (frame_err  & ~(w1c_hit & pwData[ST_FRAME_ERR]))  | set_frame_err;
            parity_err <= (parity_err & ~(w1c_hit & pwData[ST_PARITY_ERR])) | set_parity_err;
            tx_ovf     <= (tx_ovf     & ~(w1c_hit & pwData[ST_TX_OVF]))     | set_tx_ovf;
        end
    end

    // Registered interrupt combining the three enabled sources.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else begin
            irq <= (ctrl[CT_IRQ_RX_EN]  & ~rx_empty) |
                   (ctrl[CT_IRQ_ERR_EN] & (rx_ovr | frame_err | parity_err | tx_ovf)) |
                   (ctrl[CT_IRQ_TXE_EN] & tx_empty & ~tx_busy);
        end
    end

    assign tx_bit_end = (tx_cnt == 16'd0);
    assign tx_busy    = (tx_state != TX_IDLE);
    assign tx_pop     = tx_start;

    // TX next state; a frame only starts from IDLE or directly after STOP.
    always_comb begin
        tx_state_nx = tx_state;
        tx_start    = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (ctrl[CT_TX_EN] && !tx_empty) begin
                    tx_state_nx = TX_START;
                    tx_start    = 1'b1;
                end
            end
            TX_START:  if (tx_bit_end) tx_state_nx = TX_DATA;
            TX_DATA:   if (tx_bit_end && (tx_bit == LAST_BIT))
                           tx_state_nx = tx_par_en ? TX_PARITY : TX_STOP;
            TX_PARITY: if (tx_bit_end) tx_state_nx = TX_STOP;
            TX_STOP: begin
                if (tx_bit_end) begin
                    if (ctrl[CT_TX_EN] && !tx_empty) begin
                        tx_state_nx = TX_START;
                        tx_start    = 1'b1;
                    end else begin
                        tx_state_nx = TX_IDLE;
                    end
                end
            end
            default: tx_state_nx = TX_IDLE;
        endcase
    end

    // TX state and datapath; divisor and parity mode are frozen per frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state   <= TX_IDLE;
            tx_cnt     <= '0;
            tx_div     <= '0;
            tx_bit     <= '0;
            tx_shift   <= '0;
            tx_par_en  <= 1'b0;
            tx_par_bit <= 1'b0;
        end else begin
            tx_state <= tx_state_nx;
            if (tx_start) begin
                tx_div     <= div_reg;
                tx_cnt     <= div_reg - 16'd1;
                tx_shift   <= tx_dout;
                tx_bit     <= '0;
                tx_par_en  <= ctrl[CT_PAR_EN];
                tx_par_bit <= parity_of(8'(tx_dout), ctrl[CT_PAR_ODD]);
            end else if (tx_state != TX_IDLE) begin
                if (tx_bit_end) begin
                    tx_cnt <= tx_div - 16'd1;
                    if (tx_state == TX_DATA) begin
                        tx_shift <= tx_shift >> 1;
                        tx_bit   <= tx_bit + 3'd1;
                    end
                end else begin
                    tx_cnt <= tx_cnt - 16'd1;
                end
            end
        end
    end

    // Line level follows the TX state directly so reset forces idle-high at once.
    always_comb begin
        txd = 1'b1;
        case (tx_state)
            TX_START:  txd = 1'b0;
            TX_DATA:   txd = tx_shift[0];
            TX_PARITY: txd = tx_par_bit;
            default:   txd = 1'b1;
        endcase
    end

    // Two-flop synchronizer plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_s1   <= 1'b1;
            rxd_s2   <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_s1   <= rxd;
            rxd_s2   <= rxd_s1;
            rxd_prev <= rxd_s2;
        end
    end

    assign rx_fall    = rxd_prev & ~rxd_s2;
    assign rx_bit_end = (rx_cnt == 16'd0);
    assign rx_par_bad = rx_par_en && (rx_par_bit != parity_of(8'(rx_shift), rx_par_odd));

    assign set_frame_err  = rx_done && !rxd_s2;
    assign set_parity_err = rx_done && rxd_s2 && rx_par_bad;
    assign rx_good        = rx_done && rxd_s2 && !rx_par_bad;
    assign rx_push        = rx_good;
    assign set_rx_ovr     = rx_good && rx_full && !rx_pop;

    // RX next state; disabling the receiver abandons any frame in progress.
    always_comb begin
        rx_state_nx = rx_state;
        rx_begin    = 1'b0;
        rx_done     = 1'b0;
        if ((rx_state != RX_IDLE) && !ctrl[CT_RX_EN]) begin
            rx_state_nx = RX_IDLE;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (ctrl[CT_RX_EN] && rx_fall) begin
                        rx_state_nx = RX_START;
                        rx_begin    = 1'b1;
                    end
                end
                RX_START:  if (rx_bit_end) rx_state_nx = rxd_s2 ? RX_IDLE : RX_DATA;
                RX_DATA:   if (rx_bit_end && (rx_bit == LAST_BIT))
                               rx_state_nx = rx_par_en ? RX_PARITY : RX_STOP;
                RX_PARITY: if (rx_bit_end) rx_state_nx = RX_STOP;
                RX_STOP: begin
                    if (rx_bit_end) begin
                        rx_state_nx = RX_IDLE;
                        rx_done     = 1'b1;
                    end
                end
                default: rx_state_nx = RX_IDLE;
            endcase
        end
    end

    // RX state and datapath; the first wait is half a bit so later samples land mid-bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_div     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rx_par_en  <= 1'b0;
            rx_par_odd <= 1'b0;
            rx_par_bit <= 1'b0;
        end else begin
            rx_state <= rx_state_nx;
            if (rx_begin) begin
                rx_div     <= div_reg;
                rx_cnt     <= (div_reg >> 1) - 16'd1;
                rx_bit     <= '0;
                rx_par_en  <= ctrl[CT_PAR_EN];
                rx_par_odd <= ctrl[CT_PAR_ODD];
            end else if (rx_state != RX_IDLE) begin
                if (rx_bit_end) begin
                    rx_cnt <= rx_div - 16'd1;
                    if (rx_state == RX_DATA) begin
                        rx_shift <= {rxd_s2, rx_shift[DATA_BITS-1:1]};
                        rx_bit   <= rx_bit + 3'd1;
                    end
                    if (rx_state == RX_PARITY) rx_par_bit <= rxd_s2;
                end else begin
                    rx_cnt <= rx_cnt - 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_uart_fifo.sv
// Directed self-checking bench for apb_uart_fifo with default parameters.
module tb_apb_uart_fifo;

    localparam logic [1:0] SEL      = 2'b10;
    localparam int         BIT_CLKS = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pAdd;
    logic [31:0] pwData;
    logic        pwr;
    logic [1:0]  psel;
    logic        pen;
    logic        rxd;
    logic [31:0] prdata;
    logic        pready;
    logic        txd;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    apb_uart_fifo dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .pAdd   (pAdd),
        .pwData (pwData),
        .pwr    (pwr),
        .psel   (psel),
        .pen    (pen),
        .rxd    (rxd),
        .prdata (prdata),
        .pready (pready),
        .txd    (txd),
        .irq    (irq)
    );

    // Single-cycle APB write; the register updates on the posedge of the access.
    task automatic apb_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        psel   = SEL;
        pen    = 1'b1;
        pwr    = 1'b1;
        pAdd   = 32'h4000_1000 | {28'd0, a, 2'b00};
        pwData = d;
        @(posedge clk);
        #1;
        psel = 2'b00;
        pen  = 1'b0;
        pwr  = 1'b0;
    endtask

    // Single-cycle APB read; prdata is captured mid-cycle.
    task automatic apb_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        psel = SEL;
        pen  = 1'b1;
        pwr  = 1'b0;
        pAdd = 32'h4000_1000 | {28'd0, a, 2'b00};
        #1;
        d = prdata;
        @(posedge clk);
        #1;
        psel = 2'b00;
        pen  = 1'b0;
    endtask

    // Serial driver for one character at BIT_CLKS clocks per bit, followed by idle.
    task automatic send_rx(input logic [7:0] data, input logic use_par,
                           input logic par_bit, input logic stop_bit);
        @(negedge clk);
        rxd = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        if (use_par) begin
            rxd = par_bit;
            repeat (BIT_CLKS) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (BIT_CLKS) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_n = 1'b0;
        #1;
        n_checks++; if (txd !== 1'b1)     begin n_fail++; $display("[TB] FAIL reset_txd: got %b, expected 1", txd); end
        n_checks++; if (irq !== 1'b0)     begin n_fail++; $display("[TB] FAIL reset_irq: got %b, expected 0", irq); end
        n_checks++; if (prdata !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_prdata: got 0x%0h, expected 0x0", prdata); end
        n_checks++; if (pready !== 1'b0)  begin n_fail++; $display("[TB] FAIL reset_pready: got %b, expected 0", pready); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        apb_read(2'd1, d);
        n_checks++; if (d !== 32'h005)    begin n_fail++; $display("[TB] FAIL reset_status: got 0x%0h, expected 0x5", d); end
        apb_read(2'd3, d);
        n_checks++; if (d !== 32'd10416)  begin n_fail++; $display("[TB] FAIL reset_div: got %0d, expected 10416", d); end
        apb_read(2'd2, d);
        n_checks++; if (d !== 32'd0)      begin n_fail++; $display("[TB] FAIL reset_ctrl: got 0x%0h, expected 0x0", d); end
        @(negedge clk);
        psel = SEL; pen = 1'b0; pAdd = 32'h4;
        #1;
        n_checks++; if (pready !== 1'b0)  begin n_fail++; $display("[TB] FAIL setup_pready: got %b, expected 0", pready); end
        psel = 2'b01; pen = 1'b1;
        #1;
        n_checks++; if (pready !== 1'b0 || prdata !== 32'd0)
            begin n_fail++; $display("[TB] FAIL other_sel: got pready=%b prdata=0x%0h, expected 0/0x0", pready, prdata); end
        psel = SEL;
        #1;
        n_checks++; if (pready !== 1'b1 || prdata !== 32'h005)
            begin n_fail++; $display("[TB] FAIL access_pready: got pready=%b prdata=0x%0h, expected 1/0x5", pready, prdata); end
        psel = 2'b00; pen = 1'b0;
    endtask

    task automatic test_div_clamp();
        logic [31:0] d;
        apb_write(2'd3, 32'h0001_0000);
        apb_read(2'd3, d);
        n_checks++; if (d !== 32'd2) begin n_fail++; $display("[TB] FAIL div_zero: got %0d, expected 2", d); end
        apb_write(2'd3, 32'd1);
        apb_read(2'd3, d);
        n_checks++; if (d !== 32'd2) begin n_fail++; $display("[TB] FAIL div_one: got %0d, expected 2", d); end
        apb_write(2'd3, 32'd3);
        apb_read(2'd3, d);
        n_checks++; if (d !== 32'd3) begin n_fail++; $display("[TB] FAIL div_three: got %0d, expected 3", d); end
    endtask

    task automatic test_tx_frame();
        logic [31:0] d;
        logic [9:0]  frame;
        int          t;
        apb_write(2'd3, 32'd4);
        apb_write(2'd2, 32'h01);
        apb_write(2'd0, 32'hA5);
        frame = {1'b1, 8'hA5, 1'b0};
        t = 0;
        while (txd !== 1'b0 && t < 20) begin @(negedge clk); t++; end
        n_checks++; if (txd !== 1'b0) begin n_fail++; $display("[TB] FAIL tx_start_timeout: got txd=%b, expected 0", txd); end
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            n_checks++;
            if (txd !== frame[k/4]) begin
                n_fail++; $display("[TB] FAIL tx_a5_bit%0d_clk%0d: got %b, expected %b", k/4, k%4, txd, frame[k/4]);
            end
        end
        apb_read(2'd1, d);
        n_checks++; if (d !== 32'h005) begin n_fail++; $display("[TB] FAIL tx_done_status: got 0x%0h, expected 0x5", d); end
        apb_write(2'd0, 32'h5A);
        repeat (6) @(negedge clk);
        apb_read(2'd1, d);
        n_checks++; if (d !== 32'h105) begin n_fail++; $display("[TB] FAIL tx_busy_status: got 0x%0h, expected 0x105", d); end
        repeat (50) @(negedge clk);
        apb_read(2'd1, d);
        n_checks++; if (d !== 32'h005 || txd !== 1'b1)
            begin n_fail++; $display("[TB] FAIL tx_idle_after: got status=0x%0h txd=%b, expected 0x5/1", d, txd); end
    endtask

    task automatic test_rx_parity();
        logic [31:0] d;
        apb_write(2'd2, 32'h0E);
        send_rx(8'h3C, 1'b1, 1'b1, 1'b1);
        apb_read(2'd1, d);
        n_checks++; if (d !== 32'h001) begin n_fail++; $display("[TB] FAIL rx_par_ok_status: got 0x%0h, expected 0x1", d); end
        apb_read(2'd0, d);
        n_checks++; if (d !== 32'h3C)  begin n_fail++; $display("[TB] FAIL rx_par_ok_data: got 0x%0h, expected 0x3c", d); end
        apb_read(2'd1, d);
        n_checks++; if (d !== 32'h005) begin n_fail++; $display("[TB] FAIL rx_after_pop: got 0x%0h, expected 0x5", d); end
        send_rx(8'h3C, 1'b1, 1'b0, 1'b1);
        apb_read(2'd1, d);
        n_checks++; if (d !== 32'h045) begin n_fail++; $display("[TB] FAIL rx_par_bad_status: got 0x%0h, expected 0x45", d); end
        apb_read(2'd0, d);
        n_checks++; if (d !== 32'h0)   begin n_fail++; $display("[TB] FAIL rx_empty_read: got 0x%0h, expected 0x0", d); end
        apb_read(2'd1, d);
        n_checks++; if (d !== 32'h045) begin n_fail++; $display("[TB] FAIL rx_empty_read_flags: got 0x%0h, expected 0x45", d); end
        apb_write(2'd1, 32'h40);
        apb_read(2'd1, d);
        n_checks++; if (d !== 32'h005) begin n_fail++; $display("[TB] FAIL parity_w1c: got 0x%0h, expected 0x5", d); end
    endtask

    task automatic test_rx_overflow();
        logic [31:0] d;
        logic [7:0]  vals [9];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
        apb_write(2'd2, 32'h02);
        for (int i = 0; i < 9; i++) send_rx(vals[i], 1'b0, 1'b0, 1'b1);
        apb_read(2'd1, d);
        n_checks++; if (d !== 32'h019) begin n_fail++; $display("[TB] FAIL rx_ovr_status: got 0x%0h, expected 0x19", d); end
        for (int i = 0; i < 8; i++) begin
            apb_read(2'd0, d);
            n_checks++;
            if (d !== {24'd0, vals[i]}) begin
                n_fail++; $display("[TB] FAIL rx_order_%0d: got 0x%0h, expected 0x%0h", i, d, vals[i]);
            end
        end
        apb_read(2'd1, d);
        n_checks++; if (d !== 32'h015) begin n_fail++; $display("[TB] FAIL rx_drained: got 0x%0h, expected 0x15", d); end
        apb_write(2'd1, 32'h10);
        apb_read(2'd1, d);
        n_checks++; if (d !== 32'h005) begin n_fail++; $display("[TB] FAIL rx_ovr_w1c: got 0x%0h, expected 0x5", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [7:0]  words [9];
        logic [9:0]  frame;
        int          t;
        words = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h3C, 8'hC3, 8'h55, 8'hAA, 8'h77};
        apb_write(2'd2, 32'h00);
        for (int i = 0; i < 9; i++) apb_write(2'd0, {24'd0, words[i]});
        apb_read(2'd1, d);
        n_checks++; if (d !== 32'h086) begin n_fail++; $display("[TB] FAIL tx_full_ovf: got 0x%0h, expected 0x86", d); end
        apb_write(2'd2, 32'h01);
        t = 0;
        while (txd !== 1'b0 && t < 20) begin @(negedge clk); t++; end
        n_checks++; if (txd !== 1'b0) begin n_fail++; $display("[TB] FAIL b2b_start_timeout: got txd=%b, expected 0", txd); end
        for (int f = 0; f < 8; f++) begin
            frame = {1'b1, words[f], 1'b0};
            for (int k = 0; k < 40; k++) begin
                if (f > 0 || k > 0) @(negedge clk);
                n_checks++;
                if (txd !== frame[k/4]) begin
                    n_fail++; $display("[TB] FAIL b2b_f%0d_bit%0d_clk%0d: got %b, expected %b", f, k/4, k%4, txd, frame[k/4]);
                end
            end
        end
        apb_read(2'd1, d);
        n_checks++; if (d !== 32'h085) begin n_fail++; $display("[TB] FAIL b2b_done_status: got 0x%0h, expected 0x85", d); end
        apb_write(2'd1, 32'h80);
        apb_read(2'd1, d);
        n_checks++; if (d !== 32'h005) begin n_fail++; $display("[TB] FAIL tx_ovf_w1c: got 0x%0h, expected 0x5", d); end
    endtask

    task automatic test_frame_err_irq();
        logic [31:0] d;
        apb_write(2'd2, 32'h12);
        send_rx(8'h5A, 1'b0, 1'b0, 1'b0);
        apb_read(2'd1, d);
        n_checks++; if (d !== 32'h025) begin n_fail++; $display("[TB] FAIL frame_err_status: got 0x%0h, expected 0x25", d); end
        n_checks++; if (irq !== 1'b0)  begin n_fail++; $display("[TB] FAIL irq_masked: got %b, expected 0", irq); end
        apb_write(2'd2, 32'h32);
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (irq !== 1'b1)  begin n_fail++; $display("[TB] FAIL irq_err: got %b, expected 1", irq); end
        apb_write(2'd1, 32'h20);
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (irq !== 1'b0)  begin n_fail++; $display("[TB] FAIL irq_cleared: got %b, expected 0", irq); end
        apb_write(2'd2, 32'h40);
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (irq !== 1'b1)  begin n_fail++; $display("[TB] FAIL irq_tx_empty: got %b, expected 1", irq); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] d;
        int          t;
        apb_write(2'd2, 32'h01);
        apb_write(2'd0, 32'hF0);
        t = 0;
        while (txd !== 1'b0 && t < 20) begin @(negedge clk); t++; end
        n_checks++; if (txd !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_start_timeout: got txd=%b, expected 0", txd); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (txd !== 1'b1 || irq !== 1'b0)
            begin n_fail++; $display("[TB] FAIL async_reset: got txd=%b irq=%b, expected 1/0", txd, irq); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        apb_read(2'd1, d);
        n_checks++; if (d !== 32'h005)   begin n_fail++; $display("[TB] FAIL post_reset_status: got 0x%0h, expected 0x5", d); end
        apb_read(2'd3, d);
        n_checks++; if (d !== 32'd10416) begin n_fail++; $display("[TB] FAIL post_reset_div: got %0d, expected 10416", d); end
        repeat (20) @(negedge clk);
        n_checks++; if (txd !== 1'b1)    begin n_fail++; $display("[TB] FAIL post_reset_txd: got %b, expected 1", txd); end
    endtask

    // Watchdog so a stuck run still terminates.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        psel   = 2'b00;
        pen    = 1'b0;
        pwr    = 1'b0;
        pAdd   = '0;
        pwData = '0;
        rxd    = 1'b1;
        test_reset();
        test_div_clamp();
        test_tx_frame();
        test_rx_parity();
        test_rx_overflow();
        test_back_to_back();
        test_frame_err_irq();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_uart_fifo.md
Name: apb_uart_fifo

Overview:
- Next-generation APB UART peripheral: full-duplex, with TX and RX FIFOs, a runtime-programmable baud divisor, configurable data width and optional parity.
- Sits on the APB bus beside the GPIO slave; selected when psel equals PSEL_ID.
- Adds sticky error reporting, an interrupt line and FIFO status visibility, none of which the previous UART had.

Parameters:
- CLOCK_RATE, 100000000, system clock frequency in Hz.
- BAUD_RATE, 9600, reset baud rate; DIV resets to CLOCK_RATE/BAUD_RATE.
- DATA_BITS, 8, character length, legal range 5..8.
- FIFO_DEPTH, 8, entries per FIFO; power of two, minimum 2.
- PSEL_ID, 2'b10, psel value that selects this slave.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pAdd  in  32  APB address; only pAdd[3:2] is decoded.
- pwData  in  32  APB write data.
- pwr  in  1  1 = write, 0 = read.
- psel  in  2  slave select; this block is selected when psel==PSEL_ID.
- pen  in  1  APB enable (access phase).
- rxd  in  1  serial input, asynchronous to clk.
- prdata  out  32  read data.
- pready  out  1  transfer ready.
- txd  out  1  serial output; idles high.
- irq  out  1  level interrupt.

Behaviour:
- Reset values:
  - txd=1, irq=0, prdata=0, pready=0.
  - FIFOs empty, sticky flags 0.
  - CTRL=0 (TX/RX disabled, parity off).
  - DIV=CLOCK_RATE/BAUD_RATE, truncated to 16 bits.
- APB timing:
  - access = (psel==PSEL_ID) && pen.
  - pready = access, combinational; zero wait states.
  - Register side effects fire only on access cycles.
  - prdata is combinational from the register mux while access=1, otherwise 0.
- Register map (pAdd[3:2]):
  - 0 DATA:
    - Write pushes pwData[DATA_BITS-1:0] to the TX FIFO; if the TX FIFO is full the word is dropped and tx_ovf is set.
    - Read returns the RX FIFO head zero-extended and pops it.
    - Reading DATA with the RX FIFO empty returns 0, does not pop, and sets no flag.
  - 1 STATUS (read-only, except write-1-to-clear on bits 4-7):
    - bit0 tx_empty, bit1 tx_full, bit2 rx_empty, bit3 rx_full.
    - bit4 rx_ovr, bit5 frame_err, bit6 parity_err, bit7 tx_ovf.
    - bit8 tx_busy.
  - 2 CTRL (read/write):
    - bit0 tx_en, bit1 rx_en, bit2 par_en, bit3 par_odd.
    - bit4 irq_rx_en, bit5 irq_err_en, bit6 irq_tx_empty_en.
  - 3 DIV (read/write): [15:0] clocks per bit. A write of 0 or 1 is stored as 2.
- Bit timing:
  - One shared divisor value.
  - TX and RX each have an independent down-counter reloaded with DIV.
  - A DIV write takes effect at the next frame start; frames in flight keep the old value.
- TX FSM: IDLE -> START -> DATA(DATA_BITS, LSB first) -> [PARITY if par_en] -> STOP -> IDLE.
  - Leaves IDLE only when tx_en=1 and the TX FIFO is non-empty; pops the FIFO on that cycle.
  - Each state lasts DIV clocks.
  - Back-to-back frames: STOP -> START with no idle gap if the FIFO is non-empty.
  - Clearing tx_en mid-frame completes the current frame, then holds IDLE.
  - tx_busy = state != IDLE.
- Parity: even = XOR of data bits; odd = inverted even.
- RX path:
  - rxd passes through a 2-flop synchronizer.
  - IDLE: a falling edge with rx_en=1 moves the FSM to START.
  - START: at DIV/2 the line is re-sampled; if high, it is a glitch and the FSM returns to IDLE.
  - Each subsequent bit is sampled every DIV clocks, i.e. at mid-bit.
  - Stop bit sampled 0: frame_err=1, character discarded.
  - Parity mismatch: parity_err=1, character discarded.
  - Good character with RX FIFO full: character dropped, rx_ovr=1.
  - Good character otherwise: pushed at the stop-bit sample cycle.
  - Clearing rx_en mid-frame aborts to IDLE; no push, no flags.
- Simultaneous events:
  - RX push and APB pop in the same cycle: both happen and the count is unchanged. When the FIFO is full, the pop frees space first, so the push succeeds.
  - TX pop and APB push in the same cycle are handled the same way.
  - A hardware set of a sticky flag wins over a W1C clear in the same cycle.
- irq (registered) = (irq_rx_en & !rx_empty) | (irq_err_en & (rx_ovr|frame_err|parity_err|tx_ovf)) | (irq_tx_empty_en & tx_empty & !tx_busy).
- Reset mid-frame: txd returns to 1 immediately (asynchronous reset) and all state is lost.

Decomposition:
- Shared package uart_pkg holds:
  - register offsets REG_DATA=2'd0, REG_STATUS=2'd1, REG_CTRL=2'd2, REG_DIV=2'd3;
  - STATUS/CTRL bit-index constants;
  - TX and RX FSM state encodings.
- Sub-module uart_sync_fifo #(WIDTH, DEPTH), instantiated twice (TX, RX):
  - ports: push, pop, din, dout (show-ahead), full, empty;
  - pointer-plus-extra-bit full/empty detection;
  - ignores a push when full unless pop is asserted in the same cycle.

Test Plan:
- Reset -> txd=1, irq=0; STATUS reads 0x005 (tx_empty, rx_empty); DIV reads 10416 with defaults.
- DIV=4, CTRL=0x01, write DATA=0xA5 -> txd: start bit 0, then 1,0,1,0,0,1,0,1, then stop 1; each bit held 4 clocks; frame lasts 40 clocks; tx_busy=1 throughout.
- DIV=4, CTRL=0x0E (rx_en, par_en, odd), drive 0x3C with odd parity bit 1 -> DATA read returns 0x3C and rx_empty=1 afterwards. Drive the same byte with parity bit 0 -> parity_err=1 and nothing pushed.
- Fill RX with FIFO_DEPTH+1 characters without reading -> rx_full=1 and rx_ovr=1; reading returns the first 8 values in order. Writing STATUS=0x10 clears rx_ovr.
- Write 9 words to DATA with tx_en=0 -> tx_full=1 and tx_ovf=1. Then set tx_en=1 -> 8 back-to-back frames with no idle gap, after which tx_empty=1.
- CTRL=0x12, drive one character with the stop bit forced 0 -> frame_err=1, irq remains 0. Set CTRL=0x32 -> irq=1 within 2 clocks.
